dct_mult_scheduler: RTL

DCT_MULT_SCHEDULER -- requirements
Module: dct_mult_scheduler

---
 rtl/dct_mult_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/dct_mult_scheduler.sv | 106 ++++++++++
 3 files changed

// File: rtl/dct_mult_pkg.sv
// dct_mult_pkg: shared defaults and requester-ID sizing for dct_mult_scheduler.
package dct_mult_pkg;
   localparam int N_DEF    = 8;
   localparam int NREQ_DEF = 4;
   function automatic int idw_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   localparam int IDW_DEF = idw_f(NREQ_DEF);
   typedef logic [IDW_DEF-1:0] req_id_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick starting one past ptr_i; one-hot grant plus encoded index.
module rr_arbiter
   import dct_mult_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = idw_f(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  gnt_idx_o
);
   logic           found;
   logic [IDW-1:0] idx;
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(ptr_i) + k) % NREQ);
         if (en_i && !found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = idx;
         end
      end
   end
endmodule

// File: rtl/dct_mult_scheduler.sv
// dct_mult_scheduler: round-robin sharing of one 2-stage N x N multiplier among NREQ requesters.
// Optional DCT_MULT_SCHED_STATS_EN adds a saturating stall_cycles counter output.
module dct_mult_scheduler
   import dct_mult_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int NREQ = NREQ_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*N-1:0]      req_a,
   input  logic [NREQ*N-1:0]      req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [idw_f(NREQ)-1:0] rsp_id,
   output logic [2*N-1:0]         rsp_result,
`ifdef DCT_MULT_SCHED_STATS_EN
   output logic                   busy,
   output logic [15:0]            stall_cycles
`else
   output logic                   busy
`endif
);
   localparam int IDW = idw_f(NREQ);

   logic            s1_v_q, s1_v_d, s2_v_q, s2_v_d;
   logic [N-1:0]    s1_a_q, s1_a_d, s1_b_q, s1_b_d, sel_a, sel_b;
   logic [IDW-1:0]  s1_id_q, s1_id_d, s2_id_q, s2_id_d, last_q, last_d, gnt_idx;
   logic [2*N-1:0]  s2_p_q, s2_p_d;
   logic [NREQ-1:0] gnt;
   logic            s2_adv, s1_free, acc;

   assign s2_adv  = !s2_v_q || rsp_ready;
   assign s1_free = !s1_v_q || s2_adv;

   // Arbitration is held off during reset so req_ready drops with rst immediately.
   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req_i     (req_valid),
      .ptr_i     (last_q),
      .en_i      (s1_free && !rst),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   assign req_ready  = gnt;
   assign acc        = |gnt;
   assign rsp_valid  = s2_v_q;
   assign rsp_id     = s2_id_q;
   assign rsp_result = s2_p_q;
   assign busy       = s1_v_q || s2_v_q;

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++)
         if (gnt[i]) begin
            sel_a = req_a[i*N +: N];
            sel_b = req_b[i*N +: N];
         end
   end

   always_comb begin
      s1_v_d  = acc || (s1_v_q && !s2_adv);
      s1_a_d  = acc ? sel_a : s1_a_q;
      s1_b_d  = acc ? sel_b : s1_b_q;
      s1_id_d = acc ? gnt_idx : s1_id_q;
      s2_v_d  = s2_adv ? s1_v_q : s2_v_q;
      s2_p_d  = (s2_adv && s1_v_q) ? {{N{1'b0}}, s1_a_q} * {{N{1'b0}}, s1_b_q} : s2_p_q;
      s2_id_d = (s2_adv && s1_v_q) ? s1_id_q : s2_id_q;
      last_d  = acc ? gnt_idx : last_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q  <= 1'b0;
         s1_a_q  <= '0;
         s1_b_q  <= '0;
         s1_id_q <= '0;
         s2_v_q  <= 1'b0;
         s2_p_q  <= '0;
         s2_id_q <= '0;
         last_q  <= IDW'(NREQ - 1);
      end else begin
         s1_v_q  <= s1_v_d;
         s1_a_q  <= s1_a_d;
         s1_b_q  <= s1_b_d;
         s1_id_q <= s1_id_d;
         s2_v_q  <= s2_v_d;
         s2_p_q  <= s2_p_d;
         s2_id_q <= s2_id_d;
         last_q  <= last_d;
      end
   end

`ifdef DCT_MULT_SCHED_STATS_EN
   logic [15:0] stall_q, stall_d;
   assign stall_d      = (s2_v_q && !rsp_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
   assign stall_cycles = stall_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end
`endif
endmodule
